// File: rtl/mc_controller_v2_if.sv
// Control bus between the multicycle controller and the accumulator datapath.
// The master drives the datapath strobes and the slave returns opcode, flag and memory handshake.
interface mc_controller_v2_if #(
  parameter int ACW  = 2,
  parameter int ALUW = 3
);
  logic [3:0]      opcode;
  logic            flag_z;
  logic            mem_ready;
  logic            resume;
  logic            pc_write;
  logic            pc_data_sel;
  logic            mem_addr_sel;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write1;
  logic            ir_write2;
  logic            di_write;
  logic            ac_read;
  logic            ac_write;
  logic [ACW-1:0]  ac_addr_sel;
  logic [1:0]      ac_data_sel;
  logic            alu_b_sel;
  logic [ALUW-1:0] alu_cmd;
  logic            flag_en;
  logic            halted;
  logic            err;
  logic [4:0]      state;

  modport master (
    input  opcode, flag_z, mem_ready, resume,
    output pc_write, pc_data_sel, mem_addr_sel, mem_read, mem_write,
           ir_write1, ir_write2, di_write, ac_read, ac_write,
           ac_addr_sel, ac_data_sel, alu_b_sel, alu_cmd, flag_en,
           halted, err, state
  );

  modport slave (
    output opcode, flag_z, mem_ready, resume,
    input  pc_write, pc_data_sel, mem_addr_sel, mem_read, mem_write,
           ir_write1, ir_write2, di_write, ac_read, ac_write,
           ac_addr_sel, ac_data_sel, alu_b_sel, alu_cmd, flag_en,
           halted, err, state
  );
endinterface

// File: rtl/mc_controller_v2.sv
// Multicycle control FSM for the accumulator CPU: opcode decode, datapath strobes,
// memory ready/wait handshake with timeout trap, conditional jump, HALT/resume and sticky error.
module mc_controller_v2 #(
  parameter int ACW     = 2,
  parameter int ALUW    = 3,
  parameter int TW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  mc_controller_v2_if.master bus
);

  typedef enum logic [4:0] {
    S_RST   = 5'd0,
    S_F1    = 5'd1,
    S_DEC   = 5'd2,
    S_FADDR = 5'd3,
    S_LDA1  = 5'd4,
    S_LDA2  = 5'd5,
    S_STA1  = 5'd6,
    S_STA2  = 5'd7,
    S_MEMA  = 5'd8,
    S_EXA   = 5'd9,
    S_WBA   = 5'd10,
    S_ACC   = 5'd11,
    S_MVR   = 5'd12,
    S_EXR   = 5'd13,
    S_WBR   = 5'd14,
    S_LDI   = 5'd15,
    S_JMP   = 5'd16,
    S_JZ    = 5'd17,
    S_HALT  = 5'd18,
    S_ERR   = 5'd19
  } state_t;

  state_t          cur;
  state_t          nxt;
  logic [TW-1:0]   wait_cnt;
  logic            mem_state;
  logic            timed_out;

  logic            pc_write;
  logic            pc_data_sel;
  logic            mem_addr_sel;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write1;
  logic            ir_write2;
  logic            di_write;
  logic            ac_read;
  logic            ac_write;
  logic [ACW-1:0]  ac_addr_sel;
  logic [1:0]      ac_data_sel;
  logic            alu_b_sel;
  logic [ALUW-1:0] alu_cmd;
  logic            flag_en;
  logic            halted;
  logic            err;

  assign mem_state = (cur == S_F1) || (cur == S_FADDR) || (cur == S_LDA1) ||
                     (cur == S_STA2) || (cur == S_MEMA);

  // A state that already waited TIMEOUT cycles and is still not ready traps.
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TW'(TIMEOUT)) && !bus.mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur      <= S_RST;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= '0;
      else if (mem_state && !bus.mem_ready)
        wait_cnt <= wait_cnt + TW'(1);
    end
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_RST:   nxt = S_F1;
      S_F1: begin
        if (bus.mem_ready)  nxt = S_DEC;
        else if (timed_out) nxt = S_ERR;
      end
      S_DEC: begin
        casez (bus.opcode)
          4'b0???: nxt = S_FADDR;
          4'b10??: nxt = S_ACC;
          4'b1100: nxt = S_LDI;
          4'b1101: nxt = S_JZ;
          4'b1110: nxt = S_JMP;
          default: nxt = S_HALT;
        endcase
      end
      S_FADDR: begin
        if (bus.mem_ready) begin
          case (bus.opcode[2:1])
            2'b00:   nxt = S_LDA1;
            2'b01:   nxt = S_STA1;
            default: nxt = S_MEMA;
          endcase
        end else if (timed_out) begin
          nxt = S_ERR;
        end
      end
      S_LDA1: begin
        if (bus.mem_ready)  nxt = S_LDA2;
        else if (timed_out) nxt = S_ERR;
      end
      S_LDA2:  nxt = S_F1;
      S_STA1:  nxt = S_STA2;
      S_STA2: begin
        if (bus.mem_ready)  nxt = S_F1;
        else if (timed_out) nxt = S_ERR;
      end
      S_MEMA: begin
        if (bus.mem_ready)  nxt = S_EXA;
        else if (timed_out) nxt = S_ERR;
      end
      S_EXA:   nxt = S_WBA;
      S_WBA:   nxt = S_F1;
      S_ACC:   nxt = (bus.opcode[1:0] == 2'b00) ? S_MVR : S_EXR;
      S_MVR:   nxt = S_F1;
      S_EXR:   nxt = S_WBR;
      S_WBR:   nxt = S_F1;
      S_LDI:   nxt = S_F1;
      S_JMP:   nxt = S_F1;
      S_JZ:    nxt = S_F1;
      S_HALT:  if (bus.resume) nxt = S_F1;
      S_ERR:   nxt = S_ERR;
      default: nxt = S_ERR;
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    pc_data_sel  = 1'b0;
    mem_addr_sel = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write1    = 1'b0;
    ir_write2    = 1'b0;
    di_write     = 1'b0;
    ac_read      = 1'b0;
    ac_write     = 1'b0;
    ac_addr_sel  = '0;
    ac_data_sel  = 2'd0;
    alu_b_sel    = 1'b0;
    alu_cmd      = '0;
    flag_en      = 1'b0;
    halted       = 1'b0;
    err          = 1'b0;
    unique case (cur)
      S_F1: begin
        mem_read  = 1'b1;
        pc_write  = bus.mem_ready;
        ir_write1 = bus.mem_ready;
      end
      S_FADDR: begin
        mem_read  = 1'b1;
        pc_write  = bus.mem_ready;
        ir_write2 = bus.mem_ready;
      end
      S_LDA1: begin
        mem_addr_sel = 1'b1;
        mem_read     = 1'b1;
      end
      S_LDA2: begin
        ac_write    = 1'b1;
        ac_data_sel = 2'd0;
        ac_addr_sel = ACW'(0);
      end
      S_STA1: begin
        ac_read     = 1'b1;
        ac_addr_sel = ACW'(0);
      end
      S_STA2: begin
        mem_addr_sel = 1'b1;
        mem_write    = 1'b1;
      end
      S_MEMA: begin
        mem_addr_sel = 1'b1;
        mem_read     = 1'b1;
        ac_read      = 1'b1;
        ac_addr_sel  = ACW'(0);
      end
      S_EXA: begin
        alu_b_sel = 1'b1;
        alu_cmd   = bus.opcode[1] ? ALUW'(1) : ALUW'(0);
        flag_en   = 1'b1;
      end
      S_WBA: begin
        ac_write    = 1'b1;
        ac_data_sel = 2'd1;
        ac_addr_sel = ACW'(0);
      end
      S_ACC: begin
        ac_read     = 1'b1;
        ac_addr_sel = ACW'(1);
      end
      S_MVR: begin
        ac_write    = 1'b1;
        ac_addr_sel = ACW'(2);
        ac_data_sel = 2'd2;
      end
      S_EXR: begin
        alu_b_sel   = 1'b0;
        ac_read     = 1'b1;
        ac_addr_sel = ACW'(2);
        // 1001/1010/1011 map onto ADD/AND/OR
        alu_cmd     = ALUW'(bus.opcode[1:0]) - ALUW'(1);
        flag_en     = 1'b1;
      end
      S_WBR: begin
        ac_write    = 1'b1;
        ac_addr_sel = ACW'(2);
        ac_data_sel = 2'd1;
      end
      S_LDI:   di_write = 1'b1;
      S_JMP: begin
        pc_data_sel = 1'b1;
        pc_write    = 1'b1;
      end
      S_JZ: begin
        pc_data_sel = 1'b1;
        pc_write    = bus.flag_z;
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   err    = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc_write     = pc_write;
  assign bus.pc_data_sel  = pc_data_sel;
  assign bus.mem_addr_sel = mem_addr_sel;
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.ir_write1    = ir_write1;
  assign bus.ir_write2    = ir_write2;
  assign bus.di_write     = di_write;
  assign bus.ac_read      = ac_read;
  assign bus.ac_write     = ac_write;
  assign bus.ac_addr_sel  = ac_addr_sel;
  assign bus.ac_data_sel  = ac_data_sel;
  assign bus.alu_b_sel    = alu_b_sel;
  assign bus.alu_cmd      = alu_cmd;
  assign bus.flag_en      = flag_en;
  assign bus.halted       = halted;
  assign bus.err          = err;
  assign bus.state        = cur;

endmodule
